alu_divider: RTL and testbench



---
 rtl/alu_divider_if.sv | 13 +
 rtl/alu_divider.sv | 69 ++++++
 tb/tb_alu_divider.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/alu_divider_if.sv
// alu_divider_if: start/busy/done handshake and operand/result buses for the divider.
interface alu_divider_if #(parameter int N = 5, parameter int D = 3);
   logic         start;
   logic [N-1:0] X;
   logic [D-1:0] Y;
   logic         busy;
   logic         done;
   logic [N-1:0] Q;
   logic [D-1:0] R;
   logic         dz;
   modport master (output start, X, Y, input busy, done, Q, R, dz);
   modport slave  (input start, X, Y, output busy, done, Q, R, dz);
endinterface

// File: rtl/alu_divider.sv
// alu_divider: restoring divider, one quotient bit per clock, with divide-by-zero shortcut.
module alu_divider #(parameter int N = 5, parameter int D = 3) (
   input  logic          clk,
   input  logic          rst_n,
   alu_divider_if.slave  bus
);
   localparam int CW = $clog2(N);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t        state, state_nx;
   logic [N-1:0]  dvd, quo, quo_nx;
   logic [D-1:0]  dsr, rem, rem_nx;
   logic [CW-1:0] cnt;
   logic [D:0]    t, diff;
   logic          ge, last;
   assign bus.busy = state != IDLE;
   assign bus.done = state == DONE;
   // t needs D+1 bits: the partial remainder plus the next dividend bit can reach 2*dsr-1
   always_comb begin
      t        = {rem, dvd[N-1]};
      diff     = t - {1'b0, dsr};
      ge       = t >= {1'b0, dsr};
      rem_nx   = ge ? diff[D-1:0] : t[D-1:0];
      quo_nx   = {quo[N-2:0], ge};
      last     = cnt == CW'(N - 1);
      state_nx = state == IDLE ? (bus.start ? (bus.Y == '0 ? DONE : CALC) : IDLE) :
                 state == CALC ? (last ? DONE : CALC) : IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dvd   <= '0;
         dsr   <= '0;
         rem   <= '0;
         quo   <= '0;
         cnt   <= '0;
         bus.Q <= '0;
         bus.R <= '0;
         bus.dz <= 1'b0;
      end else if (state == IDLE && bus.start) begin
         if (bus.Y != '0) begin
            dvd <= bus.X;
            dsr <= bus.Y;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
         end else begin
            bus.Q  <= '1;
            bus.R  <= '0;
            bus.dz <= 1'b1;
         end
      end else if (state == CALC) begin
         dvd <= dvd << 1;
         rem <= rem_nx;
         quo <= quo_nx;
         cnt <= cnt + 1'b1;
         if (last) begin
            bus.Q  <= quo_nx;
            bus.R  <= rem_nx;
            bus.dz <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_alu_divider.sv
// tb_alu_divider: directed vector table, handshake corner cases and exhaustive identity sweep.
module tb_alu_divider;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   ntest = 0;
   int   nfail = 0;
   int   done_cnt = 0;
   int   exp_done = 0;
   alu_divider_if #(.N(5), .D(3)) bus ();
   alu_divider #(.N(5), .D(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;
   typedef struct {
      logic [4:0] x;
      logic [2:0] y;
      logic [4:0] q;
      logic [2:0] r;
      logic       dz;
   } vec_t;
   vec_t vecs[8];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      ntest++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic do_div(input logic [4:0] x, input logic [2:0] y,
                         output logic [4:0] q, output logic [2:0] r, output logic z, output int lat);
      logic busy_ok;
      @(negedge clk);
      bus.start = 1'b1;
      bus.X = x;
      bus.Y = y;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.X = 5'($urandom);
      bus.Y = 3'($urandom);
      exp_done++;
      lat = 0;
      busy_ok = 1'b1;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (bus.busy !== 1'b1) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
      chk("busy_during_op", 32'(busy_ok), 1);
      q = bus.Q;
      r = bus.R;
      z = bus.dz;
      @(posedge clk);
      #1;
      chk("idle_after_done", {30'd0, bus.busy, bus.done}, 0);
   endtask
   initial begin
      logic [4:0] q;
      logic [2:0] r;
      logic       z;
      int         lat, n, d0;
      bus.start = 1'b0;
      bus.X = '0;
      bus.Y = '0;
      vecs[0] = '{5'd23, 3'd5, 5'd4,  3'd3, 1'b0};
      vecs[1] = '{5'd31, 3'd1, 5'd31, 3'd0, 1'b0};
      vecs[2] = '{5'd7,  3'd7, 5'd1,  3'd0, 1'b0};
      vecs[3] = '{5'd3,  3'd6, 5'd0,  3'd3, 1'b0};
      vecs[4] = '{5'd0,  3'd5, 5'd0,  3'd0, 1'b0};
      vecs[5] = '{5'd30, 3'd7, 5'd4,  3'd2, 1'b0};
      vecs[6] = '{5'd19, 3'd0, 5'd31, 3'd0, 1'b1};
      vecs[7] = '{5'd19, 3'd4, 5'd4,  3'd3, 1'b0};
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {22'd0, bus.busy, bus.done, bus.Q, bus.R, bus.dz}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_div(vecs[i].x, vecs[i].y, q, r, z, lat);
         chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
         chk($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].r));
         chk($sformatf("vec%0d_dz", i), 32'(z), 32'(vecs[i].dz));
         chk($sformatf("vec%0d_latency", i), 32'(lat), vecs[i].y == 0 ? 0 : 5);
      end
      chk("done_count_vectors", 32'(done_cnt), 32'(exp_done));
      // start pulsed mid-CALC with different operands must be ignored
      @(negedge clk);
      bus.start = 1'b1;
      bus.X = 5'd23;
      bus.Y = 3'd5;
      @(negedge clk);
      bus.start = 1'b0;
      exp_done++;
      @(negedge clk);
      bus.start = 1'b1;
      bus.X = 5'd9;
      bus.Y = 3'd2;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.done !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("busy_start_done_seen", 32'(bus.done), 1);
      chk("busy_start_q", 32'(bus.Q), 4);
      chk("busy_start_r", 32'(bus.R), 3);
      repeat (12) @(negedge clk);
      chk("busy_start_one_done", 32'(done_cnt), 32'(exp_done));
      chk("busy_start_q_held", 32'(bus.Q), 4);
      // async reset two cycles into CALC
      @(negedge clk);
      bus.start = 1'b1;
      bus.X = 5'd29;
      bus.Y = 3'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      d0 = done_cnt;
      rst_n = 1'b0;
      #1;
      chk("midreset_outputs", {22'd0, bus.busy, bus.done, bus.Q, bus.R, bus.dz}, 0);
      repeat (8) @(negedge clk);
      chk("midreset_no_done", 32'(done_cnt), 32'(d0));
      rst_n = 1'b1;
      do_div(5'd17, 3'd3, q, r, z, lat);
      chk("post_reset_q", 32'(q), 5);
      chk("post_reset_r", 32'(r), 2);
      chk("post_reset_dz", 32'(z), 0);
      chk("post_reset_latency", 32'(lat), 5);
      d0 = done_cnt;
      exp_done = 0;
      for (int x = 0; x < 32; x++) begin
         for (int y = 0; y < 8; y++) begin
            do_div(5'(x), 3'(y), q, r, z, lat);
            if (y == 0) begin
               chk($sformatf("ex_%0d_%0d_dz", x, y), {23'd0, q, r, z}, {23'd0, 5'd31, 3'd0, 1'b1});
               chk($sformatf("ex_%0d_%0d_lat", x, y), 32'(lat), 0);
            end else begin
               chk($sformatf("ex_%0d_%0d_ident", x, y), 32'(int'(q) * y + int'(r)), 32'(x));
               chk($sformatf("ex_%0d_%0d_rlty", x, y), 32'(int'(r) < y), 1);
               chk($sformatf("ex_%0d_%0d_dz0", x, y), 32'(z), 0);
               chk($sformatf("ex_%0d_%0d_lat", x, y), 32'(lat), 5);
            end
         end
      end
      chk("exhaustive_done_count", 32'(done_cnt - d0), 32'(exp_done));
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
